// File: rtl/fetch_unit_pipelined_if.sv
// Fetch-stage bus bundle: redirect from execute, instruction-memory request/response
// channels and the decode-side valid/ready handshake.
interface fetch_unit_pipelined_if #(
  parameter int XLEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_pc_plus4;
  logic            misalign_fault;

  modport master (
    input  redirect_valid, redirect_target, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, if_ready,
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
           if_pc_plus4, misalign_fault
  );

  modport slave (
    output redirect_valid, redirect_target, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, if_ready,
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
           if_pc_plus4, misalign_fault
  );
endinterface

// File: rtl/fetch_unit_pipelined.sv
// Pipelined fetch stage: credit-limited in-order requests to instruction memory, a small
// PC/instruction queue toward decode, and redirect handling with wrong-path squashing.
module fetch_unit_pipelined #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              DEPTH        = 4
) (
  input logic                    clk,
  input logic                    reset,
  fetch_unit_pipelined_if.master bus
);
  localparam int             AW      = $clog2(DEPTH);
  localparam int             CW      = AW + 1;
  localparam logic [CW:0]    DEPTH_C = (CW + 1)'(DEPTH);

  typedef enum logic {RUN, HALT} state_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pc_q [DEPTH];
  logic [AW-1:0]   pq_wr;
  logic [AW-1:0]   pq_rd;
  logic [CW-1:0]   inflight_cnt;
  logic [31:0]     buf_instr [DEPTH];
  logic [XLEN-1:0] buf_pc [DEPTH];
  logic [AW-1:0]   buf_wr;
  logic [AW-1:0]   buf_rd;
  logic [CW-1:0]   buf_cnt;
  logic [CW-1:0]   drop_cnt;
  logic            misalign_q;

  logic            accept;
  logic            rsp;
  logic            buf_push;
  logic            buf_pop;
  logic            target_misaligned;
  logic [CW:0]     occupancy;

  // Credit counts both in-flight and buffered entries, so a returning response always has room.
  always_comb begin
    target_misaligned  = bus.redirect_target[1:0] != 2'b00;
    occupancy          = {1'b0, inflight_cnt} + {1'b0, buf_cnt};
    bus.imem_req_valid = !reset && (state == RUN) && !bus.redirect_valid && (occupancy < DEPTH_C);
    bus.imem_req_addr  = fetch_pc;
    bus.if_valid       = !reset && (buf_cnt != '0) && !bus.redirect_valid;
    bus.if_instr       = buf_instr[buf_rd];
    bus.if_pc          = buf_pc[buf_rd];
    bus.if_pc_plus4    = buf_pc[buf_rd] + XLEN'(4);
    bus.misalign_fault = misalign_q;
    accept             = bus.imem_req_valid && bus.imem_req_ready;
    rsp                = bus.imem_rsp_valid && (inflight_cnt != '0);
    buf_push           = rsp && (drop_cnt == '0) && !bus.redirect_valid;
    buf_pop            = bus.if_valid && bus.if_ready;
  end

  always_ff @(posedge clk) begin
    if (accept) pc_q[pq_wr] <= fetch_pc;
    if (buf_push) begin
      buf_instr[buf_wr] <= bus.imem_rsp_data;
      buf_pc[buf_wr]    <= pc_q[pq_rd];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      fetch_pc     <= RESET_VECTOR;
      pq_wr        <= '0;
      pq_rd        <= '0;
      inflight_cnt <= '0;
      buf_wr       <= '0;
      buf_rd       <= '0;
      buf_cnt      <= '0;
      drop_cnt     <= '0;
      misalign_q   <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      if (accept) begin
        fetch_pc <= fetch_pc + XLEN'(4);
        pq_wr    <= pq_wr + AW'(1);
      end
      if (rsp) pq_rd <= pq_rd + AW'(1);
      if (accept && !rsp) inflight_cnt <= inflight_cnt + CW'(1);
      else if (!accept && rsp) inflight_cnt <= inflight_cnt - CW'(1);

      // A response landing in the redirect cycle is itself wrong-path, so it is not counted again.
      if (bus.redirect_valid) begin
        buf_cnt  <= '0;
        buf_wr   <= '0;
        buf_rd   <= '0;
        drop_cnt <= inflight_cnt - CW'(rsp);
        if (target_misaligned) begin
          state      <= HALT;
          misalign_q <= 1'b1;
        end else begin
          state    <= RUN;
          fetch_pc <= bus.redirect_target;
        end
      end else begin
        if (rsp && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        if (buf_push) buf_wr <= buf_wr + AW'(1);
        if (buf_pop) buf_rd <= buf_rd + AW'(1);
        if (buf_push && !buf_pop) buf_cnt <= buf_cnt + CW'(1);
        else if (!buf_push && buf_pop) buf_cnt <= buf_cnt - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit_pipelined.sv
// Bench for fetch_unit_pipelined: queue-based reference model compared every cycle, an
// in-order variable-latency memory, directed scenarios, random traffic and a wrap-around instance.
module tb_fetch_unit_pipelined;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_unit_pipelined_if #(.XLEN(32)) bus ();
  fetch_unit_pipelined_if #(.XLEN(32)) bus_w ();

  fetch_unit_pipelined #(.XLEN(32), .RESET_VECTOR(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  fetch_unit_pipelined #(.XLEN(32), .RESET_VECTOR(32'hFFFF_FFF8), .DEPTH(4)) u_wrap (
    .clk(clk), .reset(reset), .bus(bus_w)
  );

  int checks = 0;
  int fails = 0;
  int cyc = 0;

  logic [31:0] mem_addr[$];
  int          mem_due[$];

  logic [31:0] m_pc;
  bit          m_halt;
  bit          m_fault;
  int          m_drop;
  logic [31:0] m_infl[$];
  logic [31:0] m_buf[$];
  bit          e_req;
  bit          e_ifv;

  logic        obs_req_valid;
  logic [31:0] obs_req_addr;
  logic        obs_if_valid;
  logic [31:0] obs_if_pc;
  logic        obs_fault;

  logic [31:0] seen_pc[$];
  int          cnt;
  logic [31:0] first_pc;

  logic [31:0] wrap_pc [3];
  logic [31:0] wrap_exp [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
  int          wrap_n = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_halt = 1'b0;
    m_fault = 1'b0;
    m_drop = 0;
    m_infl.delete();
    m_buf.delete();
  endtask

  task automatic compare_model();
    e_req = !m_halt && !bus.redirect_valid && (m_infl.size() + m_buf.size() < 4);
    e_ifv = (m_buf.size() > 0) && !bus.redirect_valid;
    obs_req_valid = bus.imem_req_valid;
    obs_req_addr  = bus.imem_req_addr;
    obs_if_valid  = bus.if_valid;
    obs_if_pc     = bus.if_pc;
    obs_fault     = bus.misalign_fault;
    check_output("req_valid", bus.imem_req_valid, e_req);
    if (e_req) check_output("req_addr", bus.imem_req_addr, m_pc);
    check_output("if_valid", bus.if_valid, e_ifv);
    if (e_ifv) begin
      check_output("if_pc", bus.if_pc, m_buf[0]);
      check_output("if_instr", bus.if_instr, instr_of(m_buf[0]));
      check_output("if_pc_plus4", bus.if_pc_plus4, m_buf[0] + 32'd4);
    end
    check_output("misalign_fault", bus.misalign_fault, m_fault);
  endtask

  task automatic model_update(input bit rd, input logic [31:0] tgt, input bit ir, input bit qr,
                              input bit rspv);
    logic [31:0] p;
    if (!rd && e_ifv && ir) void'(m_buf.pop_front());
    if (rspv && m_infl.size() > 0) begin
      p = m_infl.pop_front();
      if (!rd) begin
        if (m_drop > 0) m_drop--;
        else m_buf.push_back(p);
      end
    end
    if (e_req && qr) begin
      m_infl.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
    if (rd) begin
      m_buf.delete();
      m_drop = m_infl.size();
      if (tgt[1:0] != 2'b00) begin
        m_fault = 1'b1;
        m_halt = 1'b1;
      end else begin
        m_fault = 1'b0;
        m_halt = 1'b0;
        m_pc = tgt;
      end
    end else begin
      m_fault = 1'b0;
    end
  endtask

  // One clock of stimulus: drive at posedge+1, compare at negedge, advance model and memory.
  task automatic apply_stimulus(input bit rd, input logic [31:0] tgt, input bit ir, input bit qr,
                                input int lat);
    bit rspv;
    bus.redirect_valid  = rd;
    bus.redirect_target = tgt;
    bus.if_ready        = ir;
    bus.imem_req_ready  = qr;
    if (mem_addr.size() > 0 && mem_due[0] <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = instr_of(mem_addr[0]);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    @(negedge clk);
    compare_model();
    rspv = bus.imem_rsp_valid;
    if (rspv) begin
      void'(mem_addr.pop_front());
      void'(mem_due.pop_front());
    end
    if (bus.imem_req_valid && qr) begin
      mem_addr.push_back(bus.imem_req_addr);
      mem_due.push_back(cyc + lat);
    end
    model_update(rd, tgt, ir, qr, rspv);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.if_ready        = 1'b0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_rsp_valid  = 1'b0;
    bus.imem_rsp_data   = '0;
    reset = 1'b1;
    mem_addr.delete();
    mem_due.delete();
    model_reset();
    repeat (2) begin
      @(negedge clk);
      check_output("reset_req_valid", bus.imem_req_valid, 1'b0);
      check_output("reset_if_valid", bus.if_valid, 1'b0);
      check_output("reset_fault", bus.misalign_fault, 1'b0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Wrap-around instance: always-ready memory with one cycle of latency, decode always ready.
  initial begin
    logic        acc;
    logic [31:0] a;
    bus_w.redirect_valid  = 1'b0;
    bus_w.redirect_target = '0;
    bus_w.if_ready        = 1'b1;
    bus_w.imem_req_ready  = 1'b1;
    bus_w.imem_rsp_valid  = 1'b0;
    bus_w.imem_rsp_data   = '0;
    forever begin
      @(negedge clk);
      acc = bus_w.imem_req_valid;
      a   = bus_w.imem_req_addr;
      if (bus_w.if_valid && wrap_n < 3) begin
        wrap_pc[wrap_n] = bus_w.if_pc;
        wrap_n++;
      end
      @(posedge clk);
      #1;
      bus_w.imem_rsp_valid = acc && !reset;
      bus_w.imem_rsp_data  = instr_of(a);
    end
  end

  initial begin
    do_reset();

    // Streaming from the reset vector with 1-cycle memory
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b0, '0, 1'b1, 1'b1, 1);
      if (i == 0) begin
        check_output("first_req_valid", obs_req_valid, 1'b1);
        check_output("first_req_addr", obs_req_addr, 32'h0);
      end
      if (obs_if_valid) begin
        cnt++;
        seen_pc.push_back(obs_if_pc);
      end
    end
    check_output("stream_count", cnt, 18);
    check_output("stream_pc0", seen_pc[0], 32'h0);
    check_output("stream_pc1", seen_pc[1], 32'h4);
    check_output("stream_pc2", seen_pc[2], 32'h8);

    // Decode stall fills the credit window, then drains
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, '0, 1'b0, 1'b1, 1);
    check_output("stall_req_valid", obs_req_valid, 1'b0);
    check_output("stall_if_valid", obs_if_valid, 1'b1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b0, '0, 1'b1, 1'b0, 1);
      if (obs_if_valid) cnt++;
    end
    check_output("drain_count", cnt, 4);

    // Three slow requests in flight, then redirect away
    apply_stimulus(1'b1, 32'h10, 1'b1, 1'b1, 1);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, '0, 1'b0, 1'b1, 6);
    apply_stimulus(1'b1, 32'h100, 1'b1, 1'b1, 1);
    apply_stimulus(1'b0, '0, 1'b1, 1'b1, 1);
    check_output("redir_req_valid", obs_req_valid, 1'b1);
    check_output("redir_req_addr", obs_req_addr, 32'h100);
    first_pc = 32'hDEAD_BEEF;
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(1'b0, '0, 1'b1, 1'b1, 1);
      if (obs_if_valid && first_pc == 32'hDEAD_BEEF) first_pc = obs_if_pc;
    end
    check_output("redir_first_pc", first_pc, 32'h100);

    // Redirect colliding with a response and a ready decode
    for (int i = 0; i < 8; i++) apply_stimulus(1'b0, '0, 1'b1, 1'b1, 1);
    apply_stimulus(1'b1, 32'h300, 1'b1, 1'b1, 1);
    check_output("collide_if_valid", obs_if_valid, 1'b0);
    check_output("collide_req_valid", obs_req_valid, 1'b0);
    apply_stimulus(1'b0, '0, 1'b1, 1'b1, 1);
    check_output("collide_next_if_valid", obs_if_valid, 1'b0);
    check_output("collide_next_req", obs_req_valid, 1'b1);
    check_output("collide_next_addr", obs_req_addr, 32'h300);

    // Misaligned redirect halts fetch until an aligned one
    for (int i = 0; i < 6; i++) apply_stimulus(1'b0, '0, 1'b1, 1'b1, 1);
    apply_stimulus(1'b1, 32'h102, 1'b1, 1'b1, 1);
    apply_stimulus(1'b0, '0, 1'b1, 1'b1, 1);
    check_output("fault_pulse", obs_fault, 1'b1);
    check_output("halt_req_valid", obs_req_valid, 1'b0);
    apply_stimulus(1'b0, '0, 1'b1, 1'b1, 1);
    check_output("fault_clear", obs_fault, 1'b0);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, '0, 1'b1, 1'b1, 1);
    check_output("halt_still", obs_req_valid, 1'b0);
    apply_stimulus(1'b1, 32'h200, 1'b1, 1'b1, 1);
    apply_stimulus(1'b0, '0, 1'b1, 1'b1, 1);
    check_output("resume_req_valid", obs_req_valid, 1'b1);
    check_output("resume_req_addr", obs_req_addr, 32'h200);
    for (int i = 0; i < 6; i++) apply_stimulus(1'b0, '0, 1'b1, 1'b1, 1);

    // Random traffic with a reset in the middle
    for (int i = 0; i < 400; i++) begin
      bit          rd;
      logic [31:0] tgt;
      if (i == 200) do_reset();
      rd  = ($urandom_range(15) == 0);
      tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(3) == 0) tgt = tgt | 32'($urandom_range(3, 1));
      apply_stimulus(rd, tgt, $urandom_range(9) < 7, $urandom_range(9) < 7,
                     int'($urandom_range(4, 1)));
    end

    check_output("wrap_count", wrap_n, 3);
    for (int i = 0; i < wrap_n; i++) check_output("wrap_pc", wrap_pc[i], wrap_exp[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
